// File: rtl/shift_arbiter_if.sv
// Handshake bundle between requesters, the shared barrel shifter and the response consumer.
// Latency: none, this file only groups wires.
// Backpressure: carries req_valid/req_ready per requester and rsp_valid/rsp_ready for results.
//
// Signals:
//   req_valid/req_ready   per-requester request handshake (req_ready is a one-hot grant)
//   req_in/shamt/oper     packed per-requester payload, requester i at slice i
//   sh_in/shamt/oper      registered drive into the combinational shifter
//   sh_out                shifter result, valid in the same cycle as its inputs
//   rsp_valid/ready/id/data  single response channel, tagged with the requester index
//   busy                  arbiter is not idle
// Modports: slave = arbiter side, master = requester/shifter/consumer side.

interface shift_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4,
  parameter int ID_WIDTH      = 2
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_in;
  logic [NUM_REQ*SHAMT_WIDTH-1:0]   req_shamt;
  logic [NUM_REQ*2-1:0]             req_oper;

  logic [OPERAND_WIDTH-1:0]         sh_in;
  logic [SHAMT_WIDTH-1:0]           sh_shamt;
  logic [1:0]                       sh_oper;
  logic [OPERAND_WIDTH-1:0]         sh_out;

  logic                             rsp_valid;
  logic [ID_WIDTH-1:0]              rsp_id;
  logic [OPERAND_WIDTH-1:0]         rsp_data;
  logic                             rsp_ready;

  logic                             busy;

  modport slave (
    input  req_valid, req_in, req_shamt, req_oper, sh_out, rsp_ready,
    output req_ready, sh_in, sh_shamt, sh_oper, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_in, req_shamt, req_oper, sh_out, rsp_ready,
    input  req_ready, sh_in, sh_shamt, sh_oper, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational barrel shifter among NUM_REQ requesters.
// Latency: accept in cycle 0, shifter evaluated in cycle 1, rsp_valid from cycle 2 (II = 3).
// Backpressure: rsp_ready low holds the response stable and blocks all new grants.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts any request in flight
//   io_bus  shift_arbiter_if.slave: request handshake + payload, shifter drive/return,
//           tagged response channel and busy flag

module shift_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4,
  parameter int ID_WIDTH      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [ID_WIDTH-1:0]      r_prio;
  logic [ID_WIDTH-1:0]      r_id;
  logic [OPERAND_WIDTH-1:0] r_in;
  logic [SHAMT_WIDTH-1:0]   r_shamt;
  logic [1:0]               r_oper;
  logic [OPERAND_WIDTH-1:0] r_rsp_data;
  logic                     r_rsp_valid;
  logic                     r_busy;

  logic [NUM_REQ-1:0]       w_grant;
  logic [ID_WIDTH-1:0]      w_win_id;
  logic [ID_WIDTH-1:0]      w_idx;
  logic                     w_found;
  logic                     w_accept;
  logic [ID_WIDTH-1:0]      w_next_prio;
  logic [OPERAND_WIDTH-1:0] w_in;
  logic [SHAMT_WIDTH-1:0]   w_shamt;
  logic [1:0]               w_oper;

  // Rotating-priority search: visit requesters prio, prio+1, ... with wrap-around
  // and keep the first one found. The index is reduced modulo NUM_REQ so that
  // non-power-of-two requester counts wrap correctly.
  always_comb begin
    w_grant  = '0;
    w_win_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((int'(r_prio) + k) % NUM_REQ);
      if (!w_found && io_bus.req_valid[w_idx]) begin
        w_found         = 1'b1;
        w_grant[w_idx]  = 1'b1;
        w_win_id        = w_idx;
      end
    end
  end

  // Payload select driven by the one-hot grant.
  always_comb begin
    w_in    = '0;
    w_shamt = '0;
    w_oper  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_in    = io_bus.req_in[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        w_shamt = io_bus.req_shamt[i*SHAMT_WIDTH +: SHAMT_WIDTH];
        w_oper  = io_bus.req_oper[i*2 +: 2];
      end
    end
  end

  assign w_accept    = (r_state == ST_IDLE) && w_found;
  assign w_next_prio = (w_win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;

  // Pointer moves only on an accepted request, which bounds any waiter to
  // NUM_REQ-1 grants ahead of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= '0;
      r_id        <= '0;
      r_in        <= '0;
      r_shamt     <= '0;
      r_oper      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in    <= w_in;
            r_shamt <= w_shamt;
            r_oper  <= w_oper;
            r_id    <= w_win_id;
            r_prio  <= w_next_prio;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Shifter inputs have been stable from r_in/r_shamt/r_oper all cycle.
          r_rsp_data  <= io_bus.sh_out;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Grants only in IDLE; in RESP the handshake cycle itself returns to IDLE,
  // so the next grant is visible one cycle after completion.
  assign io_bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;

  assign io_bus.sh_in     = r_in;
  assign io_bus.sh_shamt  = r_shamt;
  assign io_bus.sh_oper   = r_oper;

  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_id    = r_id;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.busy      = r_busy;

endmodule
